// File: rtl/gpio_controller.sv
// Memory-mapped GPIO block: output/direction latches, synchronized inputs and rising-edge interrupts.
// Edge pending/mask/irq logic is compiled in only when GPIO_EDGE_IRQ_EN is defined.
module gpio_controller #(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 10,
    parameter int GPIO_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CLEAR,
    input  logic [ADDR_SIZE-1:0]  daddr,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [DATA_SIZE-1:0]  ddata_w,
    output logic [DATA_SIZE-1:0]  ddata_r,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam logic [2:0] REG_OUT  = 3'd0;
    localparam logic [2:0] REG_DIR  = 3'd1;
    localparam logic [2:0] REG_IN   = 3'd2;
    localparam logic [2:0] REG_PEND = 3'd3;
    localparam logic [2:0] REG_MASK = 3'd4;
    localparam logic [2:0] REG_SET  = 3'd5;
    localparam logic [2:0] REG_CLR  = 3'd6;
    localparam logic [2:0] REG_TGL  = 3'd7;

    logic [2:0]            idx;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] out_reg;
    logic [GPIO_WIDTH-1:0] dir_reg;
    logic [GPIO_WIDTH-1:0] s1;
    logic [GPIO_WIDTH-1:0] s2;
    logic [GPIO_WIDTH-1:0] rdata;
    logic [DATA_SIZE-1:0]  rdata_ext;
    logic                  unused_bits;

    assign idx         = daddr[2:0];
    assign wdata       = ddata_w[GPIO_WIDTH-1:0];
    assign unused_bits = ^{daddr[ADDR_SIZE-1:3], ddata_w[DATA_SIZE-1:GPIO_WIDTH]};

    assign gpio_out = out_reg;
    assign gpio_oe  = dir_reg;

`ifdef GPIO_EDGE_IRQ_EN
    logic [GPIO_WIDTH-1:0] prev;
    logic [GPIO_WIDTH-1:0] pend;
    logic [GPIO_WIDTH-1:0] mask;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] pend_clr;

    assign rise     = s2 & ~prev;
    assign pend_clr = (mem_write && idx == REG_PEND) ? wdata : '0;
    assign irq      = |(pend & mask);

    // A new edge is OR-ed in after the write-1 clear, so the set wins on a collision.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev <= '0;
            pend <= '0;
            mask <= '0;
        end else if (CLEAR) begin
            prev <= '0;
            pend <= '0;
            mask <= '0;
        end else begin
            prev <= s2;
            pend <= (pend & ~pend_clr) | rise;
            if (mem_write && idx == REG_MASK)
                mask <= wdata;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (idx)
            REG_OUT:  rdata = out_reg;
            REG_DIR:  rdata = dir_reg;
            REG_IN:   rdata = s2;
`ifdef GPIO_EDGE_IRQ_EN
            REG_PEND: rdata = pend;
            REG_MASK: rdata = mask;
`endif
            default:  rdata = '0;
        endcase
        rdata_ext = '0;
        rdata_ext[GPIO_WIDTH-1:0] = rdata;
    end

    // Read data is captured from pre-write state, so a same-cycle read+write sees the old value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_reg <= '0;
            dir_reg <= '0;
            s1      <= '0;
            s2      <= '0;
            ddata_r <= '0;
        end else if (CLEAR) begin
            out_reg <= '0;
            dir_reg <= '0;
            s1      <= '0;
            s2      <= '0;
            ddata_r <= '0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
            if (mem_read)
                ddata_r <= rdata_ext;
            if (mem_write) begin
                case (idx)
                    REG_OUT: out_reg <= wdata;
                    REG_DIR: dir_reg <= wdata;
                    REG_SET: out_reg <= out_reg | wdata;
                    REG_CLR: out_reg <= out_reg & ~wdata;
                    REG_TGL: out_reg <= out_reg ^ wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_controller.sv
// Self-checking bench for gpio_controller: vector table, directed edge/irq sequences and
// randomized traffic against a pin-history reference model.
module tb_gpio_controller;

`ifdef GPIO_EDGE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CLEAR;
    logic [9:0]  daddr;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] ddata_w;
    logic [31:0] ddata_r;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic        irq;

    int total = 0;
    int bad   = 0;

    gpio_controller #(.DATA_SIZE(32), .ADDR_SIZE(10), .GPIO_WIDTH(16)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CLEAR     (CLEAR),
        .daddr     (daddr),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .ddata_w   (ddata_w),
        .ddata_r   (ddata_r),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    always #5 CLK = ~CLK;

    // Reference state; h0/h1/h2 are the pin values seen at the last three clock edges.
    logic [15:0] m_out, m_dir, m_pend, m_mask;
    logic [15:0] h0, h1, h2;
    logic [31:0] m_rd;

    typedef struct {
        logic [2:0]  addr;
        logic        we;
        logic        re;
        logic [31:0] wd;
        logic [15:0] exp_out;
        logic [15:0] exp_oe;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[18];

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out  = '0;
        m_dir  = '0;
        m_pend = '0;
        m_mask = '0;
        h0     = '0;
        h1     = '0;
        h2     = '0;
        m_rd   = '0;
    endtask

    task automatic model_edge(input logic clr, input logic [2:0] addr, input logic we,
                              input logic re, input logic [31:0] wd, input logic [15:0] pin);
        logic [15:0] w;
        logic [15:0] rise;
        logic [15:0] val;
        if (clr) begin
            model_reset();
            return;
        end
        w    = wd[15:0];
        rise = h1 & ~h2;
        if (re) begin
            case (addr)
                3'd0:    val = m_out;
                3'd1:    val = m_dir;
                3'd2:    val = h1;
                3'd3:    val = IRQ_EN ? m_pend : 16'h0;
                3'd4:    val = IRQ_EN ? m_mask : 16'h0;
                default: val = 16'h0;
            endcase
            m_rd = {16'h0, val};
        end
        if (we) begin
            case (addr)
                3'd0: m_out = w;
                3'd1: m_dir = w;
                3'd3: if (IRQ_EN) m_pend = m_pend & ~w;
                3'd4: if (IRQ_EN) m_mask = w;
                3'd5: m_out = m_out | w;
                3'd6: m_out = m_out & ~w;
                3'd7: m_out = m_out ^ w;
                default: ;
            endcase
        end
        if (IRQ_EN)
            m_pend = m_pend | rise;
        h2 = h1;
        h1 = h0;
        h0 = pin;
    endtask

    task automatic check_output(input string tag);
        check_value({tag, ".gpio_out"}, {16'h0, gpio_out}, {16'h0, m_out});
        check_value({tag, ".gpio_oe"},  {16'h0, gpio_oe},  {16'h0, m_dir});
        check_value({tag, ".irq"},      {31'h0, irq},      {31'h0, IRQ_EN && ((m_pend & m_mask) != 0)});
        check_value({tag, ".ddata_r"},  ddata_r,           m_rd);
    endtask

    task automatic apply_stimulus(input logic clr, input logic [2:0] addr, input logic we,
                                  input logic re, input logic [31:0] wd, input logic [15:0] pin,
                                  input string tag);
        CLEAR     = clr;
        daddr     = {7'h0, addr};
        mem_write = we;
        mem_read  = re;
        ddata_w   = wd;
        gpio_in   = pin;
        model_edge(clr, addr, we, re, wd, pin);
        @(posedge CLK);
        #1;
        check_output(tag);
    endtask

    initial begin
        logic [15:0] pin;
        RESET     = 1'b1;
        CLEAR     = 1'b0;
        daddr     = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        ddata_w   = '0;
        gpio_in   = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_value("rst.gpio_out", {16'h0, gpio_out}, 32'h0);
        check_value("rst.gpio_oe",  {16'h0, gpio_oe},  32'h0);
        check_value("rst.irq",      {31'h0, irq},      32'h0);
        check_value("rst.ddata_r",  ddata_r,           32'h0);
        RESET = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 3'(i), 1'b0, 1'b1, 32'hFFFF_FFFF, 16'h0, "rst_read");
            check_value("rst_read.const", ddata_r, 32'h0);
        end

        vecs[0]  = '{3'd0, 1'b1, 1'b0, 32'h0000_A5A5, 16'hA5A5, 16'h0000, 32'h0};
        vecs[1]  = '{3'd5, 1'b1, 1'b0, 32'h0000_000F, 16'hA5AF, 16'h0000, 32'h0};
        vecs[2]  = '{3'd6, 1'b1, 1'b0, 32'h0000_0A00, 16'hA5AF, 16'h0000, 32'h0};
        vecs[3]  = '{3'd7, 1'b1, 1'b0, 32'h0000_FFFF, 16'h5A50, 16'h0000, 32'h0};
        vecs[4]  = '{3'd0, 1'b0, 1'b1, 32'h0,         16'h5A50, 16'h0000, 32'h0000_5A50};
        vecs[5]  = '{3'd0, 1'b1, 1'b0, 32'hFFFF_1234, 16'h1234, 16'h0000, 32'h0000_5A50};
        vecs[6]  = '{3'd0, 1'b0, 1'b1, 32'h0,         16'h1234, 16'h0000, 32'h0000_1234};
        vecs[7]  = '{3'd0, 1'b1, 1'b1, 32'h0000_5555, 16'h5555, 16'h0000, 32'h0000_1234};
        vecs[8]  = '{3'd1, 1'b1, 1'b0, 32'hFFFF_00FF, 16'h5555, 16'h00FF, 32'h0000_1234};
        vecs[9]  = '{3'd1, 1'b0, 1'b1, 32'h0,         16'h5555, 16'h00FF, 32'h0000_00FF};
        vecs[10] = '{3'd2, 1'b1, 1'b0, 32'h0000_FFFF, 16'h5555, 16'h00FF, 32'h0000_00FF};
        vecs[11] = '{3'd0, 1'b0, 1'b1, 32'h0,         16'h5555, 16'h00FF, 32'h0000_5555};
        vecs[12] = '{3'd5, 1'b0, 1'b1, 32'h0,         16'h5555, 16'h00FF, 32'h0};
        vecs[13] = '{3'd0, 1'b0, 1'b1, 32'h0,         16'h5555, 16'h00FF, 32'h0000_5555};
        vecs[14] = '{3'd6, 1'b0, 1'b1, 32'h0,         16'h5555, 16'h00FF, 32'h0};
        vecs[15] = '{3'd0, 1'b0, 1'b1, 32'h0,         16'h5555, 16'h00FF, 32'h0000_5555};
        vecs[16] = '{3'd7, 1'b0, 1'b1, 32'h0,         16'h5555, 16'h00FF, 32'h0};
        vecs[17] = '{3'd2, 1'b0, 1'b1, 32'h0,         16'h5555, 16'h00FF, 32'h0};

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(1'b0, vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].wd, 16'h0, "vec");
            check_value($sformatf("vec%0d.out", i), {16'h0, gpio_out}, {16'h0, vecs[i].exp_out});
            check_value($sformatf("vec%0d.oe", i),  {16'h0, gpio_oe},  {16'h0, vecs[i].exp_oe});
            check_value($sformatf("vec%0d.rd", i),  ddata_r,           vecs[i].exp_rd);
        end

        // Pin 0 rising: IN visible on the read loaded at the third edge, PEND set on that edge.
        apply_stimulus(1'b0, 3'd4, 1'b1, 1'b0, 32'h0000_0009, 16'h0000, "mask");
        apply_stimulus(1'b0, 3'd2, 1'b0, 1'b1, 32'h0, 16'h0001, "in1");
        check_value("in_lat1", ddata_r, 32'h0);
        apply_stimulus(1'b0, 3'd2, 1'b0, 1'b1, 32'h0, 16'h0001, "in2");
        check_value("in_lat2", ddata_r, 32'h0);
        check_value("irq_lat2", {31'h0, irq}, 32'h0);
        apply_stimulus(1'b0, 3'd2, 1'b0, 1'b1, 32'h0, 16'h0001, "in3");
        check_value("in_lat3", ddata_r, 32'h1);
        check_value("irq_lat3", {31'h0, irq}, {31'h0, IRQ_EN});
        apply_stimulus(1'b0, 3'd3, 1'b0, 1'b1, 32'h0, 16'h0001, "pend_rd");
        check_value("pend_rd", ddata_r, IRQ_EN ? 32'h1 : 32'h0);
        apply_stimulus(1'b0, 3'd3, 1'b1, 1'b0, 32'h0000_0001, 16'h0001, "pend_w1c");
        check_value("irq_cleared", {31'h0, irq}, 32'h0);
        apply_stimulus(1'b0, 3'd4, 1'b0, 1'b1, 32'h0, 16'h0001, "mask_rd");
        check_value("mask_rd", ddata_r, IRQ_EN ? 32'h9 : 32'h0);

        // Write-1-to-clear of bit 3 lands on the same edge that detects its rise.
        apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 16'h0009, "sw1");
        apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 16'h0009, "sw2");
        apply_stimulus(1'b0, 3'd3, 1'b1, 1'b0, 32'h0000_0008, 16'h0009, "sw3");
        check_value("setwins.irq", {31'h0, irq}, {31'h0, IRQ_EN});
        apply_stimulus(1'b0, 3'd3, 1'b0, 1'b1, 32'h0, 16'h0009, "sw_rd");
        check_value("setwins.pend", ddata_r, IRQ_EN ? 32'h8 : 32'h0);
        apply_stimulus(1'b0, 3'd3, 1'b1, 1'b0, 32'h0000_0008, 16'h0009, "sw_clr");
        check_value("setwins.clr", {31'h0, irq}, 32'h0);

        // Synchronous clear wipes everything, including a write issued in the same cycle.
        apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'h0000_FFFF, 16'h0009, "pre_clr");
        apply_stimulus(1'b0, 3'd1, 1'b1, 1'b1, 32'h0000_FFFF, 16'h0009, "pre_clr2");
        apply_stimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'h0000_1234, 16'h0009, "clear");
        check_value("clear.out", {16'h0, gpio_out}, 32'h0);
        check_value("clear.oe",  {16'h0, gpio_oe},  32'h0);
        check_value("clear.rd",  ddata_r,           32'h0);

        pin = 16'h0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                pin = 16'($urandom);
            apply_stimulus(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom, pin, "rand");
        end

        // Asynchronous reset mid-cycle, then held across an edge carrying a pending write.
        apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'h0000_FFFF, pin, "burst1");
        apply_stimulus(1'b0, 3'd1, 1'b1, 1'b0, 32'h0000_FFFF, pin, "burst2");
        daddr     = 10'h0;
        mem_write = 1'b1;
        ddata_w   = 32'h0000_00AA;
        #2;
        RESET = 1'b1;
        #1;
        check_value("async.out", {16'h0, gpio_out}, 32'h0);
        check_value("async.oe",  {16'h0, gpio_oe},  32'h0);
        model_reset();
        @(posedge CLK);
        #1;
        check_value("async.held", {16'h0, gpio_out}, 32'h0);
        RESET = 1'b0;
        apply_stimulus(1'b0, 3'd0, 1'b0, 1'b1, 32'h0, 16'h0, "post_rst");
        check_value("post_rst.rd", ddata_r, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
